// File: rtl/axi_led_fnd_slave.sv
// AXI4-Lite register slave for the board LED/FND peripheral: four 32-bit
// registers, direct LED drive and a 4-digit multiplexed 7-segment scanner.
module axi_led_fnd_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int LED_WIDTH          = 16,
  parameter int SCAN_DIV           = 100000
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [LED_WIDTH-1:0]            led,
  output logic [3:0]                      fnd_com,
  output logic [7:0]                      fnd_seg
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [31:0]      regs [4];
  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       digit_idx;
  logic             wr_accept;
  logic             wr_commit;
  logic             rd_accept;
  logic             rd_commit;
  logic [31:0]      fnd_data;
  logic [31:0]      fnd_ctrl;
  logic [3:0]       cur_nibble;
  logic             unused_bits;

  // Handshake rule for every channel: a transfer happens on the clock edge
  // where VALID and READY are both high; a VALID, once raised by its source,
  // stays high with stable payload until that edge.
  assign wr_accept = S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_AWREADY & ~S_AXI_BVALID;
  assign wr_commit = S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_accept = S_AXI_ARVALID & ~S_AXI_ARREADY & ~S_AXI_RVALID;
  assign rd_commit = S_AXI_ARREADY & S_AXI_ARVALID;

  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;

  assign fnd_data   = regs[1];
  assign fnd_ctrl   = regs[2];
  assign cur_nibble = fnd_data[{digit_idx, 2'b00} +: 4];
  assign led        = regs[0][LED_WIDTH-1:0];

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Write channel: AW and W are accepted together in a single-cycle pulse.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      S_AXI_AWREADY <= wr_accept;
      S_AXI_WREADY  <= wr_accept;
      if (wr_commit) begin
        for (int b = 0; b < 4; b++) begin
          if (S_AXI_WSTRB[b]) regs[S_AXI_AWADDR[3:2]][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
        end
        S_AXI_BVALID <= 1'b1;
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  // Read channel samples regs before any same-edge write lands.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else begin
      S_AXI_ARREADY <= rd_accept;
      if (rd_commit) begin
        S_AXI_RDATA  <= regs[S_AXI_ARADDR[3:2]];
        S_AXI_RVALID <= 1'b1;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  // Scan engine: the counter free-runs even while the display is disabled.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
      fnd_com   <= 4'hF;
      fnd_seg   <= 8'hFF;
    end else begin
      if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
        scan_cnt  <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (!fnd_ctrl[0]) begin
        fnd_com <= 4'hF;
        fnd_seg <= 8'hFF;
      end else begin
        fnd_com <= ~(4'b0001 << digit_idx);
        if (fnd_ctrl[7:4] >> digit_idx & 4'b0001) fnd_seg <= 8'hFF;
        else fnd_seg <= ~{fnd_ctrl[8 + {2'b00, digit_idx}], hex7seg(cur_nibble)};
      end
    end
  end

endmodule
